// File: rtl/ladybird_bus_arbiter.sv
// Two-master (D_BUS / I_BUS) round-robin arbiter onto a single downstream port,
// one outstanding transaction, address decode to access_t and response timeout.
module ladybird_bus_arbiter #(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           m_valid,
    output logic [1:0]           m_ready,
    input  logic [1:0][XLEN-1:0] m_addr,
    input  logic [1:0][XLEN-1:0] m_wdata,
    input  logic [1:0][3:0]      m_wstrb,
    input  logic [1:0]           m_write,
    output logic [1:0]           m_rvalid,
    output logic [XLEN-1:0]      m_rdata,
    output logic                 m_rerror,
    output logic                 s_valid,
    input  logic                 s_ready,
    output logic [XLEN-1:0]      s_addr,
    output logic [XLEN-1:0]      s_wdata,
    output logic [3:0]           s_wstrb,
    output logic                 s_write,
    output logic [2:0]           s_sel,
    input  logic                 s_rvalid,
    input  logic [XLEN-1:0]      s_rdata
);

    typedef enum logic [2:0] {
        ACC_IRAM = 3'b000,
        ACC_BRAM = 3'b001,
        ACC_DRAM = 3'b010,
        ACC_UART = 3'b011,
        ACC_QSPI = 3'b100,
        ACC_GPIO = 3'b101
    } access_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int TLIM  = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic BUS_D = 1'b0;
    localparam logic BUS_I = 1'b1;

    function automatic access_t access_type(input logic [XLEN-1:0] addr);
        case (addr[XLEN-1 -: 4])
            4'hF:    access_type = ACC_UART;
            4'hE:    access_type = ACC_GPIO;
            4'hD:    access_type = ACC_QSPI;
            4'h9:    access_type = ACC_IRAM;
            4'h8:    access_type = ACC_BRAM;
            default: access_type = ACC_DRAM;
        endcase
    endfunction

    state_t            state_reg, state_next;
    logic              last_grant_reg;
    logic              grant_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [XLEN-1:0]   s_addr_reg, s_wdata_reg, m_rdata_reg;
    logic [3:0]        s_wstrb_reg;
    logic              s_write_reg, m_rerror_reg;
    access_t           s_sel_reg;
    logic [1:0]        m_rvalid_reg;

    logic              grant_idx;
    logic              accept;
    logic              timeout_hit;

    // On a conflict the master that did not win last time is served.
    always_comb begin
        grant_idx = BUS_D;
        case (m_valid)
            2'b01:   grant_idx = BUS_D;
            2'b10:   grant_idx = BUS_I;
            2'b11:   grant_idx = ~last_grant_reg;
            default: grant_idx = BUS_D;
        endcase
    end

    assign accept      = (state_reg == IDLE) && (|m_valid) && !reset;
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_reg == CNT_W'(TLIM));

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ready
            assign m_ready[gi] = accept && (grant_idx == 1'(gi));
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = REQ;
            REQ:     if (s_ready) state_next = RESP;
            RESP:    if (s_rvalid || timeout_hit) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            last_grant_reg <= BUS_I;
            grant_reg      <= BUS_D;
            cnt_reg        <= '0;
            s_addr_reg     <= '0;
            s_wdata_reg    <= '0;
            s_wstrb_reg    <= '0;
            s_write_reg    <= 1'b0;
            s_sel_reg      <= access_type('0);
            m_rvalid_reg   <= '0;
            m_rdata_reg    <= '0;
            m_rerror_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            m_rvalid_reg <= '0;
            if (accept) begin
                grant_reg      <= grant_idx;
                last_grant_reg <= grant_idx;
                s_addr_reg     <= m_addr[grant_idx];
                s_wdata_reg    <= m_wdata[grant_idx];
                s_wstrb_reg    <= m_wstrb[grant_idx];
                s_write_reg    <= m_write[grant_idx];
                s_sel_reg      <= access_type(m_addr[grant_idx]);
            end
            if (state_reg == REQ && s_ready) begin
                cnt_reg <= '0;
            end
            // A response is only honoured in RESP; stray s_rvalid elsewhere is dropped.
            if (state_reg == RESP) begin
                if (s_rvalid) begin
                    m_rvalid_reg[grant_reg] <= 1'b1;
                    m_rdata_reg             <= s_rdata;
                    m_rerror_reg            <= 1'b0;
                end else if (timeout_hit) begin
                    m_rvalid_reg[grant_reg] <= 1'b1;
                    m_rdata_reg             <= '0;
                    m_rerror_reg            <= 1'b1;
                end else if (cnt_reg != '1) begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end
        end
    end

    assign s_valid  = (state_reg == REQ);
    assign s_addr   = s_addr_reg;
    assign s_wdata  = s_wdata_reg;
    assign s_wstrb  = s_wstrb_reg;
    assign s_write  = s_write_reg;
    assign s_sel    = s_sel_reg;
    assign m_rvalid = m_rvalid_reg;
    assign m_rdata  = m_rdata_reg;
    assign m_rerror = m_rerror_reg;

endmodule

// File: tb/tb_ladybird_bus_arbiter.sv
// Directed bench for ladybird_bus_arbiter: table of single transactions plus
// hand sequences for conflicts, stalls, reset in RESP and timeout.
module tb_ladybird_bus_arbiter;

    localparam int XLEN = 32;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [1:0]           m_valid;
    logic [1:0]           m_ready;
    logic [1:0][XLEN-1:0] m_addr;
    logic [1:0][XLEN-1:0] m_wdata;
    logic [1:0][3:0]      m_wstrb;
    logic [1:0]           m_write;
    logic [1:0]           m_rvalid;
    logic [XLEN-1:0]      m_rdata;
    logic                 m_rerror;
    logic                 s_valid;
    logic                 s_ready;
    logic [XLEN-1:0]      s_addr;
    logic [XLEN-1:0]      s_wdata;
    logic [3:0]           s_wstrb;
    logic                 s_write;
    logic [2:0]           s_sel;
    logic                 s_rvalid;
    logic [XLEN-1:0]      s_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    ladybird_bus_arbiter #(.XLEN(XLEN), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .reset(reset),
        .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_wstrb(m_wstrb), .m_write(m_write), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
        .m_rerror(m_rerror), .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_write(s_write), .s_sel(s_sel),
        .s_rvalid(s_rvalid), .s_rdata(s_rdata)
    );

    always #5 clk = ~clk;

    localparam logic [2:0] SEL_IRAM = 3'b000, SEL_BRAM = 3'b001, SEL_DRAM = 3'b010,
                           SEL_UART = 3'b011, SEL_QSPI = 3'b100, SEL_GPIO = 3'b101;

    typedef struct {
        int          master;
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] rdata;
        logic [2:0]  sel;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_txn(input vec_t v);
        logic [1:0] oh;
        oh = 2'b01 << v.master;
        m_valid[v.master] = 1'b1;
        m_addr[v.master]  = v.addr;
        m_wdata[v.master] = v.wdata;
        m_wstrb[v.master] = v.wstrb;
        m_write[v.master] = v.write;
        @(negedge clk);
        check("txn_m_ready", 32'(m_ready), 32'(oh));
        step();
        m_valid = 2'b00;
        s_ready = 1'b1;
        @(negedge clk);
        check("txn_s_valid", 32'(s_valid), 32'd1);
        check("txn_s_addr", s_addr, v.addr);
        check("txn_s_sel", 32'(s_sel), 32'(v.sel));
        check("txn_s_write", 32'(s_write), 32'(v.write));
        check("txn_m_ready_busy", 32'(m_ready), 32'd0);
        step();
        s_ready  = 1'b0;
        s_rvalid = 1'b1;
        s_rdata  = v.rdata;
        @(negedge clk);
        check("txn_no_early_rvalid", 32'(m_rvalid), 32'd0);
        step();
        s_rvalid = 1'b0;
        @(negedge clk);
        check("txn_m_rvalid", 32'(m_rvalid), 32'(oh));
        check("txn_m_rerror", 32'(m_rerror), 32'd0);
        if (!v.write) check("txn_m_rdata", m_rdata, v.rdata);
        $display("txn master=%0d addr=0x%08h write=%0d sel=%0d rdata=0x%08h",
                 v.master, v.addr, v.write, s_sel, m_rdata);
        step();
    endtask

    initial begin
        vecs[0] = '{0, 32'h8000_0010, 1'b0, 32'h0,         4'hF, 32'hCAFE_0A0A, SEL_BRAM};
        vecs[1] = '{1, 32'hF000_0004, 1'b0, 32'h0,         4'hF, 32'h1111_2222, SEL_UART};
        vecs[2] = '{0, 32'hE000_0008, 1'b0, 32'h0,         4'hF, 32'h3333_4444, SEL_GPIO};
        vecs[3] = '{1, 32'hD000_0000, 1'b0, 32'h0,         4'hF, 32'h5555_6666, SEL_QSPI};
        vecs[4] = '{0, 32'h9000_0040, 1'b1, 32'hDEAD_BEEF, 4'h3, 32'h0,         SEL_IRAM};
        vecs[5] = '{1, 32'h0000_1000, 1'b0, 32'h0,         4'hF, 32'h7777_8888, SEL_DRAM};
        vecs[6] = '{0, 32'h2000_0000, 1'b0, 32'h0,         4'hF, 32'h9999_AAAA, SEL_DRAM};

        reset = 1'b1; m_valid = '0; m_addr = '0; m_wdata = '0; m_wstrb = '0; m_write = '0;
        s_ready = 1'b0; s_rvalid = 1'b0; s_rdata = '0;
        step(); step();
        @(negedge clk);
        check("rst_m_ready", 32'(m_ready), 32'd0);
        check("rst_m_rvalid", 32'(m_rvalid), 32'd0);
        check("rst_m_rdata", m_rdata, 32'd0);
        check("rst_m_rerror", 32'(m_rerror), 32'd0);
        check("rst_s_valid", 32'(s_valid), 32'd0);
        check("rst_s_addr", s_addr, 32'd0);
        check("rst_s_sel", 32'(s_sel), 32'(SEL_DRAM));
        $display("reset state checked");
        step();
        reset = 1'b0;

        // Both masters held continuously: grants must alternate D, I, D, I.
        m_addr[0] = 32'hF000_0000; m_addr[1] = 32'h9000_0000; m_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rr_m_ready", 32'(m_ready), 32'(2'b01 << (i % 2)));
            if (i > 0) check("rr_m_rvalid", 32'(m_rvalid), 32'(2'b01 << ((i - 1) % 2)));
            step();
            s_ready = 1'b1;
            @(negedge clk);
            check("rr_s_sel", 32'(s_sel), (i % 2 == 0) ? 32'(SEL_UART) : 32'(SEL_IRAM));
            $display("rr grant %0d addr=0x%08h sel=%0d", i, s_addr, s_sel);
            step();
            s_ready = 1'b0; s_rvalid = 1'b1; s_rdata = 32'(i);
            step();
            s_rvalid = 1'b0;
        end
        m_valid = 2'b00;
        @(negedge clk);
        check("rr_last_rvalid", 32'(m_rvalid), 32'b10);
        check("rr_last_rdata", m_rdata, 32'd3);
        step();

        foreach (vecs[k]) run_txn(vecs[k]);

        // Write stalled five cycles by s_ready.
        m_valid[0] = 1'b1; m_addr[0] = 32'h0000_0100; m_wdata[0] = 32'hA5A5_5A5A;
        m_wstrb[0] = 4'b0011; m_write[0] = 1'b1;
        @(negedge clk);
        check("wr_m_ready", 32'(m_ready), 32'b01);
        step();
        m_valid = 2'b00; m_addr[0] = 32'hFFFF_FFFF; m_wdata[0] = '0; m_wstrb[0] = '0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("wr_stall_s_valid", 32'(s_valid), 32'd1);
            check("wr_stall_fields", {s_wdata[15:0], 8'(s_addr), 3'(s_wstrb), s_write},
                  {16'h5A5A, 8'h00, 3'b011, 1'b1});
            step();
        end
        $display("write stall held for 5 cycles");
        s_ready = 1'b1;
        step();
        s_ready = 1'b0; s_rvalid = 1'b1;
        step();
        s_rvalid = 1'b0;
        @(negedge clk);
        check("wr_ack", 32'(m_rvalid), 32'b01);
        step();
        @(negedge clk);
        check("wr_ack_once", 32'(m_rvalid), 32'd0);
        $display("write acked");

        // Reset while in RESP: no response, last grant returns to I_BUS.
        m_valid[0] = 1'b1; m_addr[0] = 32'h8000_0020; m_write[0] = 1'b0;
        step();
        m_valid = 2'b00; s_ready = 1'b1;
        step();
        s_ready = 1'b0; reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        check("rstresp_s_valid", 32'(s_valid), 32'd0);
        check("rstresp_s_addr", s_addr, 32'd0);
        check("rstresp_s_sel", 32'(s_sel), 32'(SEL_DRAM));
        check("rstresp_m_rvalid", 32'(m_rvalid), 32'd0);
        check("rstresp_m_rdata", m_rdata, 32'd0);
        step();
        @(negedge clk);
        check("rstresp_no_rvalid", 32'(m_rvalid), 32'd0);
        step();
        m_valid = 2'b11; m_addr[0] = 32'h8000_0000; m_addr[1] = 32'h9000_0000;
        @(negedge clk);
        check("rstresp_first_grant", 32'(m_ready), 32'b01);
        $display("post-reset conflict granted to %0d", m_ready);
        step();
        m_valid = 2'b00; s_ready = 1'b1;
        step();
        s_ready = 1'b0; s_rvalid = 1'b1; s_rdata = 32'h1234_5678;
        step();
        s_rvalid = 1'b0;
        @(negedge clk);
        check("rstresp_txn_rvalid", 32'(m_rvalid), 32'b01);
        step();

        // Timeout with TIMEOUT_CYCLES=8: response exactly 8 cycles after entering RESP.
        m_valid[1] = 1'b1; m_addr[1] = 32'h0000_0200;
        step();
        m_valid = 2'b00; s_ready = 1'b1;
        step();
        s_ready = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check("to_wait", 32'(m_rvalid), 32'd0);
            step();
        end
        @(negedge clk);
        check("to_m_rvalid", 32'(m_rvalid), 32'b10);
        check("to_m_rerror", 32'(m_rerror), 32'd1);
        check("to_m_rdata", m_rdata, 32'd0);
        $display("timeout rvalid=%b rerror=%0d rdata=0x%08h", m_rvalid, m_rerror, m_rdata);
        step();
        s_rvalid = 1'b1; s_rdata = 32'hBAD0_BAD0;
        step();
        s_rvalid = 1'b0;
        @(negedge clk);
        check("late_rvalid_ignored", 32'(m_rvalid), 32'd0);
        check("late_rdata_kept", m_rdata, 32'd0);
        check("late_rerror_kept", 32'(m_rerror), 32'd1);
        $display("late s_rvalid ignored");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ladybird_bus_arbiter.md
# ladybird_bus_arbiter

Shares one downstream memory/peripheral port between the core's two bus masters, I_BUS (fetch) and D_BUS (load/store). It arbitrates round-robin and allows one outstanding transaction at a time. It decodes the captured address into an `access_t` peripheral select via `ACCESS_TYPE()`, and it converts a non-responding slave into an error response after a programmable timeout. It sits between the core and the IRAM/BRAM/DRAM/UART/QSPI/GPIO interconnect.

## Interface
- `TIMEOUT_CYCLES`, default 1024: cycles `RESP` waits for `s_rvalid` before an error response; 0 disables the timeout.
- `clk`  in  1  sole clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `m_valid`  in  2  request per master; index 0 = D_BUS, index 1 = I_BUS (`core_bus_t` encoding).
- `m_ready`  out  2  one-hot accept strobe, one cycle.
- `m_addr`  in  2×XLEN  request byte address per master.
- `m_wdata`  in  2×XLEN  write data per master.
- `m_wstrb`  in  2×4  byte enables per master.
- `m_write`  in  2  1 = write, 0 = read.
- `m_rvalid`  out  2  one-hot response strobe, one cycle.
- `m_rdata`  out  XLEN  response data, shared and qualified by `m_rvalid`.
- `m_rerror`  out  1  response is a timeout error, qualified by `m_rvalid`.
- `s_valid`  out  1  downstream request.
- `s_ready`  in  1  downstream accepts the request.
- `s_addr`  out  XLEN  captured address.
- `s_wdata`  out  XLEN  captured write data.
- `s_wstrb`  out  4  captured byte enables.
- `s_write`  out  1  captured write flag.
- `s_sel`  out  3  `access_t` = `ACCESS_TYPE(s_addr)`, registered at capture.
- `s_rvalid`  in  1  downstream response; also used as the write acknowledge.
- `s_rdata`  in  XLEN  downstream read data.

## Operation
- The state machine has three states: `IDLE`, `REQ` and `RESP`.
- **IDLE:** if any `m_valid` is set, grant one master.
  - The granted master's `m_ready` is 1 combinationally in this cycle.
  - On the clock edge, the block captures that master's addr, wdata, wstrb and write, and `s_sel`, and records the grant index. Next state is `REQ`.
- **REQ:** `s_valid`=1 and the captured fields are held stable. When `s_ready`=1, go to `RESP` and clear the timeout counter.
- **RESP:** wait for `s_rvalid`.
  - On `s_rvalid`, register `s_rdata` into `m_rdata`, set `m_rerror`=0, pulse `m_rvalid[grant]` in the next cycle, and return to `IDLE`.
  - If `TIMEOUT_CYCLES`≠0 and the counter reaches `TIMEOUT_CYCLES`-1 without `s_rvalid`, pulse `m_rvalid[grant]` with `m_rdata`=0 and `m_rerror`=1, and return to `IDLE`.
  - After a timeout, any late `s_rvalid` that arrives in `IDLE` or `REQ` is ignored.
- **Arbitration:**
  - A single requester always wins.
  - When both request, the master not granted most recently wins.
  - After reset, the last-grant pointer is I_BUS, so D_BUS wins the first conflict.
- A master must hold `m_valid` and its fields stable until `m_ready`. Dropping `m_valid` before grant withdraws the request with no side effect.
- `m_ready` is never asserted outside `IDLE`.
- Writes also complete through `RESP`. `m_rvalid` is the write acknowledge and `m_rdata` is undefined for a write.
- The timeout counter is `$clog2(TIMEOUT_CYCLES+1)` bits, saturating, and counts only in `RESP`.

## Timing
- **Reset values:**
  - State `IDLE`; last-grant = I_BUS.
  - `m_ready`=0, `m_rvalid`=0, `m_rdata`=0, `m_rerror`=0.
  - `s_valid`=0, `s_addr`=0, `s_wdata`=0, `s_wstrb`=0, `s_write`=0.
  - `s_sel` = `ACCESS_TYPE(0)` = DRAM (3'b010).
- Reset mid-transaction aborts with no `m_rvalid`. The downstream slave must itself be reset by the same `reset`.
- **Best-case latency:**
  - Accept at cycle 0.
  - `s_valid` at cycle 1 with `s_ready`=1.
  - `s_rvalid` at cycle 2.
  - `m_rvalid` at cycle 3.
  - Next accept at cycle 3 at the earliest, because the state is `IDLE` in that cycle.
- **Throughput:** one transaction per 3 cycles maximum.
- `m_rvalid` is a registered one-cycle pulse. `m_rdata` and `m_rerror` hold until the next response.
- `m_ready` and `m_rvalid` may both be 1 in the same cycle for different masters, or for the same master.
- An `s_rvalid` in the same cycle as `s_ready` is not accepted. A response is recognised only in `RESP`, one cycle after the `s_ready` handshake.

## Test plan
- **Single D read:** D `m_valid`, addr 0x8000_0010 -> `m_ready[0]` cycle 0; `s_valid` with `s_sel`=BRAM cycle 1; slave ready + `s_rdata`=0xCAFE0A0A -> `m_rvalid[0]`, `m_rdata`=0xCAFE0A0A, `m_rerror`=0.
- **Simultaneous requests after reset:** D wins first (`s_sel`=UART for 0xF000_0000), then I (0x9000_0000 -> IRAM). Both held continuously -> grants alternate D, I, D, I.
- **Write with stall:** D write wstrb 4'b0011, `s_ready` low 5 cycles -> `s_valid` and fields stable all 5 cycles; ack -> `m_rvalid[0]`=1 once.
- **Timeout:** `TIMEOUT_CYCLES`=8, slave never responds -> `m_rvalid` exactly 8 cycles after entering `RESP`, `m_rerror`=1, `m_rdata`=0. A late `s_rvalid` then produces no `m_rvalid`.
- **Reset mid-RESP:** reset asserted in `RESP` -> next cycle all outputs at reset values, no `m_rvalid`. The first post-reset conflict is granted to D.
- **Decode sweep:** addresses with top nibble F/E/D/8/9/0/2 -> `s_sel` UART/GPIO/QSPI/BRAM/IRAM/DRAM/DRAM.
